// File: rtl/module_display_scan_ctrl_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment words are active-low, bit order {g,f,e,d,c,b,a}.
package pkg_display;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/module_display_scan_ctrl_bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles (A-F) render as a dash.
module module_bcd_to_7seg
   import pkg_display::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/module_display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free frame commit.
// Optional leading-zero suppression: define DISPLAY_LZ_SUPPRESS_EN.
module module_display_scan_ctrl
   import pkg_display::*;
#(
   parameter int DIGITS          = 2,
   parameter int DISPLAY_REFRESH = 27000,
   parameter int BLANK_CYCLES    = 270
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [4*DIGITS-1:0] bcd_i,
   input  logic                bcd_valid_i,
   output logic                bcd_ready_o,
   output logic [DIGITS-1:0]   anodo_o,
   output logic [6:0]          catodo_o,
   output logic                frame_done_o,
   output state_t              state_o
);

   localparam int CW = (DISPLAY_REFRESH > 1) ? $clog2(DISPLAY_REFRESH) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DISPLAY_REFRESH - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [DW-1:0]       digit, digit_nxt;
   logic [4*DIGITS-1:0] disp, disp_nxt;
   logic [4*DIGITS-1:0] pend;
   logic                pend_full, pend_full_nxt;
   logic                boundary, transfer;
   logic [3:0]          nib_sel;
   logic [6:0]          seg_dec;
   logic                lz_blank;
   logic [DIGITS-1:0]   anodo_nxt;
   logic [6:0]          catodo_nxt;

   // Handshake: a word transfers on any edge where bcd_valid_i and
   // bcd_ready_o are both high; ready stays low while the pending buffer
   // is full, so later valids are ignored rather than overwriting it.
   assign transfer = bcd_valid_i && bcd_ready_o;
   assign boundary = (cnt == CNT_LAST) && (digit == DIG_LAST);
   assign state_o  = state;

   always_comb begin
      cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      digit_nxt = digit;
      state_nxt = state;
      if (cnt == CNT_LAST)
         digit_nxt = (digit == DIG_LAST) ? '0 : digit + 1'b1;
      if (state == S_BLANK && cnt == BLANK_LAST)
         state_nxt = S_DRIVE;
      else if (state == S_DRIVE && cnt == CNT_LAST)
         state_nxt = S_BLANK;

      disp_nxt      = (boundary && pend_full) ? pend : disp;
      pend_full_nxt = pend_full;
      if (transfer)
         pend_full_nxt = 1'b1;
      else if (boundary)
         pend_full_nxt = 1'b0;
   end

   // Outputs are computed from next-state so the registered pins line up
   // with the FSM/counter/digit registers in the same cycle.
   always_comb begin
      nib_sel   = '0;
      anodo_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (digit_nxt == DW'(k)) begin
            nib_sel = disp_nxt[4*k +: 4];
            if (state_nxt == S_DRIVE)
               anodo_nxt[k] = 1'b0;
         end
      end
   end

`ifdef DISPLAY_LZ_SUPPRESS_EN
   logic zero_run;
   always_comb begin
      lz_blank = 1'b0;
      zero_run = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (disp_nxt[4*k +: 4] == 4'd0);
         if (digit_nxt == DW'(k) && zero_run)
            lz_blank = 1'b1;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   module_bcd_to_7seg u_dec (
      .nibble (nib_sel),
      .seg    (seg_dec)
   );

   assign catodo_nxt = (state_nxt == S_DRIVE && !lz_blank) ? seg_dec : SEG_BLANK;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_BLANK;
         cnt          <= '0;
         digit        <= '0;
         disp         <= '0;
         pend         <= '0;
         pend_full    <= 1'b0;
         bcd_ready_o  <= 1'b1;
         frame_done_o <= 1'b0;
         anodo_o      <= '1;
         catodo_o     <= SEG_BLANK;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         digit        <= digit_nxt;
         disp         <= disp_nxt;
         if (transfer)
            pend <= bcd_i;
         pend_full    <= pend_full_nxt;
         bcd_ready_o  <= !pend_full_nxt;
         frame_done_o <= boundary;
         anodo_o      <= anodo_nxt;
         catodo_o     <= catodo_nxt;
      end
   end

endmodule

// File: doc/module_display_scan_ctrl.md
Name: module_display_scan_ctrl

Overview:
- Time-multiplexed 7-segment scan controller with tear-free frame update.
- Accepts a packed BCD word from the bin-to-BCD stage through a valid/ready handshake and holds it in a pending buffer.
- Commits the pending word only at a frame boundary, then drives the anodes and cathodes one digit at a time with a blanking dead-time between digits to suppress ghosting.
- Sits between the BCD converter and the board display pins in the top level.

Parameters:
- DIGITS, 2: number of multiplexed digits; must be ≥ 1.
- DISPLAY_REFRESH, 27000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 270: blanked cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < DISPLAY_REFRESH.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- bcd_i  in  4*DIGITS  packed BCD; nibble k drives digit k, and nibble 0 is the least significant digit
- bcd_valid_i  in  1  bcd_i valid
- bcd_ready_o  out  1  pending buffer empty; a value can be accepted
- anodo_o  out  DIGITS  digit enables, active-low; bit k is digit k
- catodo_o  out  7  segments, active-low; bit order {g,f,e,d,c,b,a}
- frame_done_o  out  1  one-cycle pulse after each frame commit

Interface:
- One clock, clk_i.
- Reset rst_i is synchronous and active-high.

Behaviour:
- Reset values, one edge after rst_i is sampled high:
  - anodo_o = all 1s; catodo_o = 7'h7F.
  - bcd_ready_o = 1; frame_done_o = 0.
  - Display register = 0; pending buffer empty.
  - Slot counter = 0; digit index = 0; FSM in S_BLANK.
- Reset mid-operation discards any pending value; the cycle-0 values above apply.
- FSM:
  - S_BLANK: slot counter in 0..BLANK_CYCLES-1. anodo_o all 1s, catodo_o 7'h7F. Moves to S_DRIVE when counter = BLANK_CYCLES-1.
  - S_DRIVE: slot counter in BLANK_CYCLES..DISPLAY_REFRESH-1. anodo_o has only bit [digit] low; catodo_o = seg(display nibble[digit]). When counter = DISPLAY_REFRESH-1: counter wraps to 0, digit increments (DIGITS-1 wraps to 0), FSM returns to S_BLANK.
- All outputs are registered. anodo_o and catodo_o reflect the FSM, counter and digit state of the same cycle, with no added latency.
- Frame boundary is the cycle where counter = DISPLAY_REFRESH-1 and digit = DIGITS-1. At that edge:
  - If the pending buffer is full, it is copied into the display register and the buffer is marked empty, so bcd_ready_o = 1 in the next cycle.
  - frame_done_o = 1 for exactly the next cycle, whether or not a commit occurred.
- Handshake:
  - Transfer occurs when bcd_valid_i and bcd_ready_o are both high.
  - On transfer, bcd_i is latched into the pending buffer and bcd_ready_o = 0 from the next cycle.
  - bcd_valid_i while bcd_ready_o = 0 is ignored; there is no overwrite.
  - A transfer in the frame-boundary cycle itself fills the pending buffer only; it is committed at the following boundary.
- Segment map, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles A–F show a dash: 0111111.
- Display changes mid-frame are impossible, because the display register is only written at the frame boundary.

Optional Feature:
- Macro: DISPLAY_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. In S_DRIVE, digit k > 0 shows catodo_o = 7'h7F if nibbles DIGITS-1..k are all 0. Digit 0 always displays; anodo_o timing is unchanged.
- Undefined: every digit is decoded normally, so 0 shows 1000000.

Decomposition:
- Shared package pkg_display:
  - Segment constants SEG_BLANK (7'h7F) and SEG_DASH (7'b0111111).
  - The 0–9 segment encodings.
  - FSM state typedef {S_BLANK, S_DRIVE}.
- Sub-module module_bcd_to_7seg: a purely combinational nibble-to-segment decoder, instantiated once on the muxed nibble.

Test Plan:
Bench parameters: DIGITS=2, DISPLAY_REFRESH=8, BLANK_CYCLES=2.
- Reset: hold rst_i 2 cycles → anodo_o=2'b11, catodo_o=7'h7F, bcd_ready_o=1, frame_done_o=0.
- Scan: load 8'h42, wait for commit, then observe one frame:
  - Slot 0: 2 blank cycles, then 6 cycles of anodo_o=2'b10, catodo_o=0100100.
  - Slot 1: 2 blank cycles, then 6 cycles of anodo_o=2'b01, catodo_o=0011001.
  - frame_done_o high for exactly 1 cycle per 16.
- Handshake: send 8'h37 mid-frame → bcd_ready_o=0 next cycle; a second valid with 8'h99 is ignored; display still 42 until the boundary, then 3/7; ready=1 the cycle after commit.
- Invalid nibble: 8'hA5 → digit 1 shows 0111111, digit 0 shows 0010010.
- Reset mid-S_DRIVE with pending 8'h11 → reset values next cycle; after release, digits show 0 and 8'h11 is never displayed.
- Leading zeros: 8'h07 → with DISPLAY_LZ_SUPPRESS_EN, digit 1 catodo_o=7'h7F; without it, 1000000. Digit 0 = 1111000 in both cases.
